reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
Parametrised successor to the 8x8 two-read/one-write CPU register file. Width, depth and read-port count are generics. Adds an optional hardwired zero register, an optional write-to-read bypass, and a sequenced multi-cycle CLEAR operation with a busy flag. Sits in the CPU datapath between decode/ALU and the writeback mux. The write port is stalled by the data-memory BUSYWAIT.

Parameters:
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH registers
NUM_READ, 2, number of asynchronous read ports (1..4)
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
BYPASS, 0, 1 = a read of the address being written this cycle returns IN
READ_DELAY, 2, read path delay in time units
WRITE_DELAY, 1, write/clear delay after the clock edge in time units

Ports:
CLK  input  1  clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
IN  input  DATA_WIDTH  write data
INADDRESS  input  ADDR_WIDTH  write address
WRITE  input  1  write enable
BUSYWAIT  input  1  memory stall; blocks register writes while high
CLEAR  input  1  request a sequenced clear of all registers
OUTADDRESS  input  NUM_READ*ADDR_WIDTH  read addresses; port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
OUT  output  NUM_READ*DATA_WIDTH  read data; port k at [k*DATA_WIDTH +: DATA_WIDTH]
CLR_BUSY  output  1  high while the clear sequence runs
WR_DONE  output  1  one-cycle pulse; a write committed at the last edge

Behaviour:
- Reset is synchronous and active-high on RESET, with clock CLK.
- RESET high at a posedge, applied after WRITE_DELAY:
  - all DEPTH registers = 0
  - FSM -> IDLE, clear counter = 0
  - CLR_BUSY = 0, WR_DONE = 0
- RESET overrides everything, including a clear in progress and a simultaneous WRITE or CLEAR.
- Reads are asynchronous.
  - OUT port k = REGISTER[addr k] after READ_DELAY.
  - Any number of ports may read the same address.
  - ZERO_REG=1 and addr k = 0 -> port k reads 0.
- Bypass (BYPASS=1 only):
  - Condition: WRITE && !BUSYWAIT && FSM==IDLE && !CLEAR && addr k == INADDRESS, and not (ZERO_REG && INADDRESS==0).
  - When met, port k = IN, combinational, after READ_DELAY.
  - BYPASS=0: the written value becomes visible only after the edge plus WRITE_DELAY.
- Write commits at a posedge when: !RESET && FSM==IDLE && !CLEAR && WRITE && !BUSYWAIT.
  - REGISTER[INADDRESS] = IN after WRITE_DELAY.
  - WR_DONE = 1 for that cycle, otherwise 0.
  - ZERO_REG=1 with INADDRESS==0: write dropped, WR_DONE still pulses.
- WRITE while BUSYWAIT high: no change and no pulse. The writer holds WRITE/IN/INADDRESS; the write commits at the first edge with BUSYWAIT low.
- FSM has two states, IDLE and CLEARING.
  - IDLE -> CLEARING on a posedge with CLEAR=1 (and !RESET). Counter = 0, CLR_BUSY = 1.
  - Each CLEARING edge: REGISTER[counter] = 0, counter += 1.
  - At the edge that clears DEPTH-1: -> IDLE, CLR_BUSY = 0, counter wraps to 0.
  - Total: CLR_BUSY is high for exactly DEPTH cycles. Registers are zero from the DEPTH-th edge after the CLEAR edge.
- Clear boundary cases:
  - CLEAR and a valid WRITE at the same IDLE edge: clear wins, write dropped, no WR_DONE.
  - WRITE during CLEARING: ignored, no WR_DONE. The writer must wait for CLR_BUSY low.
  - CLEAR during CLEARING: ignored; the sequence does not restart.
  - BUSYWAIT has no effect on the clear sequence.
  - Reads during CLEARING return current contents (a partially cleared file is visible).
- Width rules: addresses are unsigned and never exceed DEPTH-1, since DEPTH = 2**ADDR_WIDTH. Data is stored unmodified.

Test Plan:
1. Reset, then write 0x5A to r3 and 0xC3 to r7 (WRITE=1, BUSYWAIT=0) -> WR_DONE pulses each edge; OUT0 addr3 = 0x5A and OUT1 addr7 = 0xC3, READ_DELAY after the commit.
2. BUSYWAIT=1 for 3 cycles with WRITE r2 = 0x11 held -> r2 unchanged and no WR_DONE for 3 edges; commit plus WR_DONE on the first edge after BUSYWAIT falls.
3. Fill all 8 registers with 0xFF, pulse CLEAR -> CLR_BUSY high for exactly 8 cycles; r0..r7 cleared one per edge in order; a WRITE r4 = 0x22 mid-sequence is ignored; all read 0 at the end.
4. Assert RESET at the 3rd clear cycle -> all registers 0, CLR_BUSY 0 at the next edge; a following CLEAR restarts from r0.
5. BYPASS=1 and NUM_READ=3: read ports on r5, r5, r1 while writing r5 = 0x3C -> ports 0 and 1 show 0x3C before the edge, port 2 shows r1. BYPASS=0: ports show the old r5 until the edge plus WRITE_DELAY.
6. ZERO_REG=1, DATA_WIDTH=16, ADDR_WIDTH=4: write 0xBEEF to r0 and to r15 -> r0 reads 0x0000 with WR_DONE pulsed; r15 reads 0xBEEF; CLEAR gives CLR_BUSY high for 16 cycles.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised CPU register file: NUM_READ asynchronous read ports, one write port stalled by BUSYWAIT,
// optional hardwired zero register and write-to-read bypass, and a one-register-per-cycle CLEAR sequence.
module reg_file_param #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned NUM_READ    = 2,
    parameter bit          ZERO_REG    = 1'b0,
    parameter bit          BYPASS      = 1'b0,
    parameter int          READ_DELAY  = 2,
    parameter int          WRITE_DELAY = 1
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [DATA_WIDTH-1:0]          IN,
    input  logic [ADDR_WIDTH-1:0]          INADDRESS,
    input  logic                           WRITE,
    input  logic                           BUSYWAIT,
    input  logic                           CLEAR,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
    output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
    output logic                           CLR_BUSY,
    output logic                           WR_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // READ_DELAY/WRITE_DELAY describe the timing of the surrounding datapath; the logic itself is zero-delay.
    if (NUM_READ < 1 || NUM_READ > 4 || READ_DELAY < 0 || WRITE_DELAY < 0) begin : g_bad_params
        $error("reg_file_param: NUM_READ must be 1..4 and delays must be non-negative");
    end

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    wr_done_q, wr_done_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    logic                    wr_zero_drop;
    logic                    wr_commit;
    logic                    wr_en;
    logic                    clr_en;
    logic                    byp_en;

    assign wr_zero_drop = ZERO_REG && (INADDRESS == '0);

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RESET) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_done_q <= wr_done_d;
        end
    end

    // Next-state logic. CLEAR in IDLE takes priority over a write at the same edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr_cnt_d = '0;
                if (CLEAR) begin
                    state_d = ST_CLEARING;
                end else begin
                    wr_done_d = WRITE && !BUSYWAIT;
                end
            end
            ST_CLEARING: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: visible flags and the array strobes.
    always_comb begin
        CLR_BUSY  = (state_q == ST_CLEARING);
        WR_DONE   = wr_done_q;
        wr_commit = (state_q == ST_IDLE) && !CLEAR && WRITE && !BUSYWAIT;
        wr_en     = wr_commit && !wr_zero_drop;
        clr_en    = (state_q == ST_CLEARING);
        byp_en    = BYPASS && wr_en;
    end

    // Register array: reset, one clear step, or one write per edge.
    always_ff @(posedge CLK) begin
        // NOTE: the array is built from flops, so every entry is reset here; a RAM macro could not be.
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_en) begin
            regs_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[INADDRESS] <= IN;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;

        assign rd_addr = OUTADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            if (ZERO_REG && (rd_addr == '0)) begin
                rd_data = '0;
            end else if (byp_en && (rd_addr == INADDRESS)) begin
                rd_data = IN;
            end else begin
                rd_data = regs_q[rd_addr];
            end
        end

        assign OUT[k*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three instances cover the default 8x8 file, a 3-port bypass
// file and a 16-bit zero-register file; expectations are queued with stimulus and drained after sampling.
module tb_reg_file_param;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    // Instance A: 8x8, two ports, no bypass, no zero register.
    logic [7:0]  a_in;
    logic [2:0]  a_inaddr;
    logic        a_write, a_busy, a_clear;
    logic [5:0]  a_outaddr;
    logic [15:0] a_out;
    logic        a_clr_busy, a_wr_done;

    // Instance B: 8x8, three ports, bypass.
    logic [7:0]  b_in;
    logic [2:0]  b_inaddr;
    logic        b_write, b_busy, b_clear;
    logic [8:0]  b_outaddr;
    logic [23:0] b_out;
    logic        b_clr_busy, b_wr_done;

    // Instance C: 16x16, two ports, zero register.
    logic [15:0] c_in;
    logic [3:0]  c_inaddr;
    logic        c_write, c_busy, c_clear;
    logic [7:0]  c_outaddr;
    logic [31:0] c_out;
    logic        c_clr_busy, c_wr_done;

    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .IN(a_in), .INADDRESS(a_inaddr), .WRITE(a_write), .BUSYWAIT(a_busy),
        .CLEAR(a_clear), .OUTADDRESS(a_outaddr), .OUT(a_out), .CLR_BUSY(a_clr_busy), .WR_DONE(a_wr_done)
    );

    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .IN(b_in), .INADDRESS(b_inaddr), .WRITE(b_write), .BUSYWAIT(b_busy),
        .CLEAR(b_clear), .OUTADDRESS(b_outaddr), .OUT(b_out), .CLR_BUSY(b_clr_busy), .WR_DONE(b_wr_done)
    );

    reg_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_READ(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_c (
        .CLK(CLK), .RESET(RESET), .IN(c_in), .INADDRESS(c_inaddr), .WRITE(c_write), .BUSYWAIT(c_busy),
        .CLEAR(c_clear), .OUTADDRESS(c_outaddr), .OUT(c_out), .CLR_BUSY(c_clr_busy), .WR_DONE(c_wr_done)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] got[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  model_a [8];

    // Inputs change 4 time units after the rising edge; outputs are sampled there or a few units later.
    task automatic step();
        @(posedge CLK);
        #4;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] g;
        RESET = 1'b1;
        a_in = '0; a_inaddr = '0; a_write = 1'b0; a_busy = 1'b0; a_clear = 1'b0; a_outaddr = '0;
        b_in = '0; b_inaddr = '0; b_write = 1'b0; b_busy = 1'b0; b_clear = 1'b0; b_outaddr = '0;
        c_in = '0; c_inaddr = '0; c_write = 1'b0; c_busy = 1'b0; c_clear = 1'b0; c_outaddr = '0;
        for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
        step();
        step();
        RESET = 1'b0;
        sb.push_back('{"reset a clr_busy", 32'd0}); got.push_back(32'(a_clr_busy));
        sb.push_back('{"reset a wr_done", 32'd0});  got.push_back(32'(a_wr_done));
        sb.push_back('{"reset c clr_busy", 32'd0}); got.push_back(32'(c_clr_busy));
        for (int p = 0; p < 4; p++) begin
            a_outaddr = {3'(2*p+1), 3'(2*p)};
            sb.push_back('{$sformatf("reset r%0d", 2*p), 32'd0});
            sb.push_back('{$sformatf("reset r%0d", 2*p+1), 32'd0});
            #1;
            got.push_back(32'(a_out[7:0]));
            got.push_back(32'(a_out[15:8]));
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_write();
        exp_t        e;
        logic [31:0] g;
        a_outaddr = {3'd7, 3'd3};
        a_write = 1'b1; a_busy = 1'b0; a_inaddr = 3'd3; a_in = 8'h5A; model_a[3] = 8'h5A;
        sb.push_back('{"write r3 wr_done", 32'd1});
        sb.push_back('{"write r3 out0", 32'h5A});
        step();
        got.push_back(32'(a_wr_done));
        got.push_back(32'(a_out[7:0]));
        a_inaddr = 3'd7; a_in = 8'hC3; model_a[7] = 8'hC3;
        sb.push_back('{"write r7 wr_done", 32'd1});
        sb.push_back('{"write r7 out1", 32'hC3});
        sb.push_back('{"write r3 out0 held", 32'h5A});
        step();
        got.push_back(32'(a_wr_done));
        got.push_back(32'(a_out[15:8]));
        got.push_back(32'(a_out[7:0]));
        a_write = 1'b0;
        sb.push_back('{"idle wr_done", 32'd0});
        step();
        got.push_back(32'(a_wr_done));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_busywait();
        exp_t        e;
        logic [31:0] g;
        a_outaddr = {3'd3, 3'd2};
        a_write = 1'b1; a_busy = 1'b1; a_inaddr = 3'd2; a_in = 8'h11;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{$sformatf("busywait %0d wr_done", i), 32'd0});
            sb.push_back('{$sformatf("busywait %0d r2", i), 32'(model_a[2])});
            step();
            got.push_back(32'(a_wr_done));
            got.push_back(32'(a_out[7:0]));
        end
        a_busy = 1'b0; model_a[2] = 8'h11;
        sb.push_back('{"busywait release wr_done", 32'd1});
        sb.push_back('{"busywait release r2", 32'h11});
        step();
        got.push_back(32'(a_wr_done));
        got.push_back(32'(a_out[7:0]));
        a_write = 1'b0;
        step();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_clear();
        exp_t        e;
        logic [31:0] g;
        a_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_inaddr = 3'(i); a_in = 8'hFF; model_a[i] = 8'hFF;
            sb.push_back('{$sformatf("fill r%0d wr_done", i), 32'd1});
            step();
            got.push_back(32'(a_wr_done));
        end
        a_write = 1'b0; a_clear = 1'b1;
        sb.push_back('{"clear start clr_busy", 32'd1});
        step();
        a_clear = 1'b0;
        got.push_back(32'(a_clr_busy));
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin a_write = 1'b1; a_inaddr = 3'd4; a_in = 8'h22; end
            if (i == 4) a_write = 1'b0;
            if (i == 5) a_clear = 1'b1;
            if (i == 6) a_clear = 1'b0;
            a_outaddr = {3'((i+1) % 8), 3'(i)};
            model_a[i] = 8'h00;
            sb.push_back('{$sformatf("clear edge %0d clr_busy", i), (i < 7) ? 32'd1 : 32'd0});
            sb.push_back('{$sformatf("clear edge %0d wr_done", i), 32'd0});
            sb.push_back('{$sformatf("clear edge %0d r%0d", i, i), 32'd0});
            sb.push_back('{$sformatf("clear edge %0d r%0d", i, (i+1) % 8), 32'(model_a[(i+1) % 8])});
            step();
            got.push_back(32'(a_clr_busy));
            got.push_back(32'(a_wr_done));
            got.push_back(32'(a_out[7:0]));
            got.push_back(32'(a_out[15:8]));
        end
        for (int p = 0; p < 4; p++) begin
            a_outaddr = {3'(2*p+1), 3'(2*p)};
            sb.push_back('{$sformatf("cleared r%0d", 2*p), 32'd0});
            sb.push_back('{$sformatf("cleared r%0d", 2*p+1), 32'd0});
            #1;
            got.push_back(32'(a_out[7:0]));
            got.push_back(32'(a_out[15:8]));
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        exp_t        e;
        logic [31:0] g;
        a_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_inaddr = 3'(i); a_in = 8'(8'h11 * i + 1); model_a[i] = 8'(8'h11 * i + 1);
            step();
        end
        a_write = 1'b0; a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        step();
        step();
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
        sb.push_back('{"mid-clear reset clr_busy", 32'd0});
        sb.push_back('{"mid-clear reset wr_done", 32'd0});
        step();
        RESET = 1'b0;
        got.push_back(32'(a_clr_busy));
        got.push_back(32'(a_wr_done));
        for (int p = 0; p < 4; p++) begin
            a_outaddr = {3'(2*p+1), 3'(2*p)};
            sb.push_back('{$sformatf("mid-clear reset r%0d", 2*p), 32'd0});
            sb.push_back('{$sformatf("mid-clear reset r%0d", 2*p+1), 32'd0});
            #1;
            got.push_back(32'(a_out[7:0]));
            got.push_back(32'(a_out[15:8]));
        end
        a_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_inaddr = 3'(i); a_in = 8'(8'h0F + 3 * i); model_a[i] = 8'(8'h0F + 3 * i);
            step();
        end
        a_clear = 1'b1; a_inaddr = 3'd6; a_in = 8'h77;
        sb.push_back('{"clear+write wr_done", 32'd0});
        step();
        a_clear = 1'b0; a_write = 1'b0;
        got.push_back(32'(a_wr_done));
        a_outaddr = {3'd6, 3'd6};
        sb.push_back('{"clear+write r6 dropped", 32'(model_a[6])});
        #1;
        got.push_back(32'(a_out[7:0]));
        a_outaddr = {3'd1, 3'd0};
        model_a[0] = 8'h00;
        sb.push_back('{"restart clears r0", 32'd0});
        sb.push_back('{"restart keeps r1", 32'(model_a[1])});
        step();
        got.push_back(32'(a_out[7:0]));
        got.push_back(32'(a_out[15:8]));
        for (int k = 0; k < 40 && a_clr_busy; k++) step();
        for (int i = 0; i < 8; i++) model_a[i] = 8'h00;
        sb.push_back('{"restart done clr_busy", 32'd0});
        got.push_back(32'(a_clr_busy));
        a_outaddr = {3'd7, 3'd6};
        sb.push_back('{"restart done r6", 32'd0});
        sb.push_back('{"restart done r7", 32'd0});
        #1;
        got.push_back(32'(a_out[7:0]));
        got.push_back(32'(a_out[15:8]));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_no_bypass();
        exp_t        e;
        logic [31:0] g;
        a_outaddr = {3'd5, 3'd5};
        a_write = 1'b1; a_inaddr = 3'd5; a_in = 8'h3C;
        sb.push_back('{"no-bypass pre-edge out0", 32'(model_a[5])});
        sb.push_back('{"no-bypass pre-edge out1", 32'(model_a[5])});
        #1;
        got.push_back(32'(a_out[7:0]));
        got.push_back(32'(a_out[15:8]));
        model_a[5] = 8'h3C;
        sb.push_back('{"no-bypass post-edge out0", 32'h3C});
        sb.push_back('{"no-bypass post-edge out1", 32'h3C});
        step();
        a_write = 1'b0;
        got.push_back(32'(a_out[7:0]));
        got.push_back(32'(a_out[15:8]));
        step();
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t        e;
        logic [31:0] g;
        b_write = 1'b1; b_inaddr = 3'd1; b_in = 8'h99;
        step();
        b_inaddr = 3'd5; b_in = 8'h10;
        step();
        b_outaddr = {3'd1, 3'd5, 3'd5};
        b_inaddr = 3'd5; b_in = 8'h3C; b_busy = 1'b1;
        sb.push_back('{"bypass busy p0", 32'h10});
        sb.push_back('{"bypass busy p1", 32'h10});
        sb.push_back('{"bypass busy p2", 32'h99});
        #1;
        for (int k = 0; k < 3; k++) got.push_back(32'(b_out[k*8 +: 8]));
        b_busy = 1'b0;
        sb.push_back('{"bypass pre-edge p0", 32'h3C});
        sb.push_back('{"bypass pre-edge p1", 32'h3C});
        sb.push_back('{"bypass pre-edge p2", 32'h99});
        #1;
        for (int k = 0; k < 3; k++) got.push_back(32'(b_out[k*8 +: 8]));
        b_clear = 1'b1; b_in = 8'h44;
        sb.push_back('{"bypass blocked by clear p0", 32'h10});
        #1;
        got.push_back(32'(b_out[7:0]));
        b_clear = 1'b0; b_in = 8'h3C;
        sb.push_back('{"bypass commit wr_done", 32'd1});
        sb.push_back('{"bypass post-edge p0", 32'h3C});
        sb.push_back('{"bypass post-edge p1", 32'h3C});
        sb.push_back('{"bypass post-edge p2", 32'h99});
        step();
        b_write = 1'b0;
        #1;
        got.push_back(32'(b_wr_done));
        for (int k = 0; k < 3; k++) got.push_back(32'(b_out[k*8 +: 8]));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    task automatic test_zero_reg();
        exp_t        e;
        logic [31:0] g;
        int          n;
        c_outaddr = {4'd15, 4'd0};
        c_write = 1'b1; c_inaddr = 4'd0; c_in = 16'hBEEF;
        sb.push_back('{"zero r0 wr_done", 32'd1});
        sb.push_back('{"zero r0 read", 32'h0000});
        step();
        got.push_back(32'(c_wr_done));
        got.push_back(32'(c_out[15:0]));
        c_inaddr = 4'd15;
        sb.push_back('{"zero r15 wr_done", 32'd1});
        sb.push_back('{"zero r15 read", 32'hBEEF});
        step();
        got.push_back(32'(c_wr_done));
        got.push_back(32'(c_out[31:16]));
        c_write = 1'b0; c_clear = 1'b1;
        sb.push_back('{"zero clear busy cycles", 32'd16});
        sb.push_back('{"zero cleared r15", 32'h0000});
        step();
        c_clear = 1'b0;
        n = 0;
        while (c_clr_busy && n < 40) begin
            n++;
            step();
        end
        got.push_back(32'(n));
        got.push_back(32'(c_out[31:16]));
        while (sb.size() != 0) begin
            e = sb.pop_front();
            g = (got.size() != 0) ? got.pop_front() : 32'hxxxx_xxxx;
            vectors++;
            if (g !== e.val) begin
                miscompares++;
                $display("FAIL %s: observed 0x%0h, expected 0x%0h", e.tag, g, e.val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_busywait();
        test_clear();
        test_reset_mid_clear();
        test_no_bypass();
        test_bypass();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
